// File: rtl/cpu_defs.sv
// Shared CPU front-end definitions: BTB request structs, sizing default and
// the PC-to-index/tag helpers used by the branch target buffer.
package cpu_defs;

  localparam int BTB_ENTRIES = 64;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } btb_update_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } btb_invalid_t;

  // Results are 32 bits wide; callers narrow them to their own IDX_W/TAG_W.
  function automatic logic [31:0] btb_idx(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/btb_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2 (
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    // NOTE: default first so every path assigns ctr_next and no latch is inferred.
    ctr_next = ctr;
    if (taken) begin
      if (ctr != 2'b11) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/btb.sv
// Direct-mapped, full-tag branch target buffer with 2-bit direction counters
// and a registered one-cycle lookup feeding fetch1.
module btb
  import cpu_defs::*;
#(
  parameter int ENTRIES = BTB_ENTRIES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lookup_en,
  input  logic [31:0]  lookup_pc,
  output logic         is_pred,
  output logic [31:0]  btb_pre,
  input  btb_update_t  upd,
  input  btb_invalid_t btb_invalid
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx, i_idx;
  logic [TAG_W-1:0] l_tag, u_tag, i_tag;
  logic             l_hit, u_hit, i_hit;
  logic             u_alloc, inv_apply;
  logic [1:0]       u_ctr_next;

  assign l_idx = IDX_W'(btb_idx(lookup_pc, IDX_W));
  assign l_tag = TAG_W'(btb_tag(lookup_pc, IDX_W));
  assign u_idx = IDX_W'(btb_idx(upd.pc, IDX_W));
  assign u_tag = TAG_W'(btb_tag(upd.pc, IDX_W));
  assign i_idx = IDX_W'(btb_idx(btb_invalid.pc, IDX_W));
  assign i_tag = TAG_W'(btb_tag(btb_invalid.pc, IDX_W));

  // A lookup only redirects when the entry also predicts taken.
  assign l_hit = valid[l_idx] && (tag_mem[l_idx] == l_tag) && ctr_mem[l_idx][1];
  assign u_hit = valid[u_idx] && (tag_mem[u_idx] == u_tag);
  assign i_hit = valid[i_idx] && (tag_mem[i_idx] == i_tag);

  assign u_alloc   = upd.valid && !u_hit && upd.taken;
  // Training takes priority over fetch2's kill when both hit the same slot.
  assign inv_apply = btb_invalid.valid && i_hit && !(upd.valid && (u_idx == i_idx));

  sat_counter2 u_ctr (
    .ctr      (ctr_mem[u_idx]),
    .taken    (upd.taken),
    .ctr_next (u_ctr_next)
  );

  // NOTE: only the valid vector is reset; tag/target/ctr stay reset-free so they map onto RAM.
  always_ff @(posedge clk) begin
    if (upd.valid) begin
      if (u_hit) begin
        ctr_mem[u_idx] <= u_ctr_next;
        if (upd.taken) target_mem[u_idx] <= upd.target;
      end else if (upd.taken) begin
        tag_mem[u_idx]    <= u_tag;
        target_mem[u_idx] <= upd.target;
        ctr_mem[u_idx]    <= 2'b10;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every read in this edge sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (inv_apply) valid[i_idx] <= 1'b0;
      if (u_alloc)   valid[u_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_pred <= 1'b0;
      btb_pre <= '0;
    end else if (lookup_en) begin
      is_pred <= l_hit;
      btb_pre <= l_hit ? target_mem[l_idx] : lookup_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_btb.sv
// Directed self-checking bench for the branch target buffer.
module tb_btb;
  import cpu_defs::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         lookup_en;
  logic [31:0]  lookup_pc;
  logic         is_pred;
  logic [31:0]  btb_pre;
  btb_update_t  upd;
  btb_invalid_t btb_invalid;

  int n_cmp = 0;
  int n_bad = 0;

  btb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_en   (lookup_en),
    .lookup_pc   (lookup_pc),
    .is_pred     (is_pred),
    .btb_pre     (btb_pre),
    .upd         (upd),
    .btb_invalid (btb_invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_pred(input string tag, input logic p, input logic [31:0] tgt);
    check({tag, ".is_pred"}, {31'd0, is_pred}, {31'd0, p});
    check({tag, ".btb_pre"}, btb_pre, tgt);
  endtask

  task automatic clear_in();
    lookup_en   = 1'b0;
    lookup_pc   = 32'h0;
    upd         = '0;
    btb_invalid = '0;
  endtask

  // Apply whatever inputs are set for one edge, sample 1ns later, then idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    upd = '{valid: 1'b1, pc: pc, target: tgt, taken: tk};
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    set_upd(pc, tgt, tk);
    cyc();
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_en = 1'b1;
    lookup_pc = pc;
    cyc();
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    #12;
    expect_pred("reset", 1'b0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss predicts fall-through.
    do_lookup(32'h1c000000);
    expect_pred("cold_miss", 1'b0, 32'h1c000004);

    // Allocate on taken miss (ctr=10).
    do_upd(32'h1c000010, 32'h1c000100, 1'b1);
    do_lookup(32'h1c000010);
    expect_pred("alloc", 1'b1, 32'h1c000100);

    // Not-taken miss leaves the table alone.
    do_upd(32'h1c000020, 32'h1c000200, 1'b0);
    do_lookup(32'h1c000020);
    expect_pred("nt_miss", 1'b0, 32'h1c000024);

    // Counter walk: 10 -> 01 -> 00 -> 00 (saturate low).
    do_upd(32'h1c000010, 32'h0, 1'b0);
    do_lookup(32'h1c000010);
    expect_pred("ctr01", 1'b0, 32'h1c000014);
    do_upd(32'h1c000010, 32'h0, 1'b0);
    do_upd(32'h1c000010, 32'h0, 1'b0);
    do_lookup(32'h1c000010);
    expect_pred("ctr00_sat", 1'b0, 32'h1c000014);
    // 00 -> 01 -> 10, taken hit also retargets.
    do_upd(32'h1c000010, 32'h1c000100, 1'b1);
    do_lookup(32'h1c000010);
    expect_pred("ctr01_up", 1'b0, 32'h1c000014);
    do_upd(32'h1c000010, 32'h1c000180, 1'b1);
    do_lookup(32'h1c000010);
    expect_pred("ctr10_retarget", 1'b1, 32'h1c000180);
    // 10 -> 11 -> 11, then two not-taken: 10 (still taken) and 01.
    do_upd(32'h1c000010, 32'h1c000100, 1'b1);
    do_upd(32'h1c000010, 32'h1c000100, 1'b1);
    do_upd(32'h1c000010, 32'h1c000100, 1'b1);
    do_upd(32'h1c000010, 32'h0, 1'b0);
    do_lookup(32'h1c000010);
    expect_pred("ctr11_sat_dec1", 1'b1, 32'h1c000100);
    do_upd(32'h1c000010, 32'h0, 1'b0);
    do_lookup(32'h1c000010);
    expect_pred("ctr11_sat_dec2", 1'b0, 32'h1c000014);

    // Alias: same index, different tag must not kill the entry.
    do_upd(32'h1c000010, 32'h1c000100, 1'b1);
    btb_invalid = '{valid: 1'b1, pc: 32'h1c000110};
    cyc();
    do_lookup(32'h1c000010);
    expect_pred("alias_survive", 1'b1, 32'h1c000100);
    do_lookup(32'h1c000110);
    expect_pred("alias_miss", 1'b0, 32'h1c000114);
    btb_invalid = '{valid: 1'b1, pc: 32'h1c000010};
    cyc();
    do_lookup(32'h1c000010);
    expect_pred("inv_kill", 1'b0, 32'h1c000014);

    // Same-index upd and invalidate: upd wins.
    do_upd(32'h1c000030, 32'h1c000200, 1'b1);
    set_upd(32'h1c000030, 32'h1c000300, 1'b1);
    btb_invalid = '{valid: 1'b1, pc: 32'h1c000030};
    cyc();
    do_lookup(32'h1c000030);
    expect_pred("same_idx_upd_wins", 1'b1, 32'h1c000300);

    // Different indices: both apply.
    do_upd(32'h1c000040, 32'h1c000400, 1'b1);
    set_upd(32'h1c000050, 32'h1c000500, 1'b1);
    btb_invalid = '{valid: 1'b1, pc: 32'h1c000040};
    cyc();
    do_lookup(32'h1c000050);
    expect_pred("diff_idx_upd", 1'b1, 32'h1c000500);
    do_lookup(32'h1c000040);
    expect_pred("diff_idx_inv", 1'b0, 32'h1c000044);

    // Stall: outputs hold while the entry is trained down.
    do_lookup(32'h1c000050);
    lookup_pc = 32'h1c000000;
    set_upd(32'h1c000050, 32'h0, 1'b0);
    cyc();
    expect_pred("hold1", 1'b1, 32'h1c000500);
    lookup_pc = 32'h1c000000;
    set_upd(32'h1c000050, 32'h0, 1'b0);
    cyc();
    expect_pred("hold2", 1'b1, 32'h1c000500);
    do_lookup(32'h1c000050);
    expect_pred("hold_release", 1'b0, 32'h1c000054);

    // Same-cycle lookup and write returns pre-write contents.
    lookup_en = 1'b1;
    lookup_pc = 32'h1c000060;
    set_upd(32'h1c000060, 32'h1c000600, 1'b1);
    cyc();
    expect_pred("rw_upd_old", 1'b0, 32'h1c000064);
    do_lookup(32'h1c000060);
    expect_pred("rw_upd_new", 1'b1, 32'h1c000600);
    lookup_en = 1'b1;
    lookup_pc = 32'h1c000060;
    btb_invalid = '{valid: 1'b1, pc: 32'h1c000060};
    cyc();
    expect_pred("rw_inv_old", 1'b1, 32'h1c000600);
    do_lookup(32'h1c000060);
    expect_pred("rw_inv_new", 1'b0, 32'h1c000064);

    // pc+4 wraps at the top of the address space.
    do_lookup(32'hfffffffc);
    expect_pred("wrap", 1'b0, 32'h00000000);

    // Mid-stream reset clears predictions and all valid bits.
    do_upd(32'h1c000070, 32'h1c000700, 1'b1);
    do_lookup(32'h1c000070);
    expect_pred("pre_reset", 1'b1, 32'h1c000700);
    #2;
    rst_n = 1'b0;
    #1;
    expect_pred("async_reset", 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_lookup(32'h1c000070);
    expect_pred("post_reset70", 1'b0, 32'h1c000074);
    do_lookup(32'h1c000030);
    expect_pred("post_reset30", 1'b0, 32'h1c000034);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
